// File: rtl/fsm_deserializer_640_4.sv
`default_nettype none
// ============================================================================
// Module   : fsm_deserializer_640_4
// Purpose  : Receive-side lane deserializer. Tracks a LANES-phase cycle,
//            gathers LANES serial lanes of DATA_W bits into one packed word,
//            tags the last word of each LINE_LEN-lane image row and offers it
//            on a valid/ready interface.
// Ports    : clk        - rising-edge clock
//            reset      - synchronous, active-high reset
//            in_valid   - serial lane valid
//            in_data    - serial lane data (DATA_W)
//            in_ready   - lane accepted this cycle when in_valid is also high
//            out_valid  - packed word valid
//            out_data   - packed word, lane k at [k*DATA_W +: DATA_W]
//            out_last   - word is the last of its row (qualified by out_valid)
//            out_ready  - downstream accepts the word
//            phase      - index of the next lane to be accepted
//            col        - word-column index of the next word to be produced
// Revision : 1.0 - initial release
// ============================================================================
module fsm_deserializer_640_4 #(
    parameter int DATA_W   = 8,
    parameter int LANES    = 4,
    parameter int LINE_LEN = 640,
    parameter int COL_W    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic [1:0]              phase,
    output logic [COL_W-1:0]        col
);

    // Phase states P0..P(LANES-1); the phase register is 2 bits wide.
    localparam logic [1:0]       c_P0       = 2'd0;
    localparam logic [1:0]       c_PLAST    = 2'(LANES - 1);
    localparam logic [COL_W-1:0] c_LAST_COL = COL_W'(LINE_LEN / LANES - 1);
    localparam int               c_ASM_W    = (LANES - 1) * DATA_W;

    logic [1:0]              r_phase;
    logic [1:0]              w_phase_next;
    logic [COL_W-1:0]        r_col;
    logic [c_ASM_W-1:0]      r_asm;
    logic [LANES*DATA_W-1:0] r_out_data;
    logic                    r_out_valid;
    logic                    r_out_last;

    logic w_in_ready;
    logic w_accept;
    logic w_word_load;
    logic w_phase_legal;

    // Only the completing lane can stall: it needs the output register,
    // which is busy while a word is held and not being taken this cycle.
    assign w_in_ready    = !((r_phase == c_PLAST) && r_out_valid && !out_ready);
    assign w_accept      = in_valid && w_in_ready;
    assign w_word_load   = w_accept && (r_phase == c_PLAST);
    assign w_phase_legal = (32'(r_phase) < 32'(LANES));

    // ------------------------------------------------------------------
    // Phase FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= c_P0;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    // ------------------------------------------------------------------
    // Phase FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_phase_next = r_phase;
        if (!w_phase_legal) begin
            // Unreachable encodings recover to the first phase.
            w_phase_next = c_P0;
        end else if (w_accept) begin
            if (r_phase == c_PLAST) begin
                w_phase_next = c_P0;
            end else begin
                w_phase_next = r_phase + 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Assembly register, output register and word-column counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_asm       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_col       <= '0;
        end else begin
            // Lanes before the last go into their slot of the assembly
            // register; these are accepted even while a word is stalled.
            for (int k = 0; k < LANES - 1; k++) begin
                if (w_accept && (r_phase == 2'(k))) begin
                    r_asm[k*DATA_W +: DATA_W] <= in_data;
                end
            end

            if (w_word_load) begin
                // The completing lane bypasses the assembly register so the
                // word is visible the cycle after that lane is presented.
                // A simultaneous output handshake is covered here too: the
                // old word leaves and the new one replaces it, valid stays 1.
                r_out_data  <= {in_data, r_asm};
                r_out_valid <= 1'b1;
                r_out_last  <= (r_col == c_LAST_COL);
                if (r_col == c_LAST_COL) begin
                    r_col <= '0;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign phase     = r_phase;
    assign col       = r_col;

endmodule
`default_nettype wire

// File: tb/tb_fsm_deserializer_640_4.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_deserializer_640_4
// Purpose  : Scoreboard bench for fsm_deserializer_640_4. The lane driver
//            pushes each expected packed word when its completing lane is
//            accepted; an independent monitor pops and compares on every
//            output handshake and checks that stalled words stay stable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_deserializer_640_4;

    localparam int DW = 8;
    localparam int L  = 4;
    localparam int LL = 640;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [L*DW-1:0] out_data;
    logic          out_last;
    logic          out_ready;
    logic [1:0]    phase;
    logic [CW-1:0] col;

    fsm_deserializer_640_4 #(
        .DATA_W  (DW),
        .LANES   (L),
        .LINE_LEN(LL),
        .COL_W   (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last),
        .out_ready(out_ready),
        .phase    (phase),
        .col      (col)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard and reference model of the lane packing
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] m_lanes[4];
    int         m_ph;
    int         m_col;
    int         n_words = 0;
    logic       rnd_ready = 1'b0;

    task automatic model_reset();
        m_ph  = 0;
        m_col = 0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic [7:0] d);
        exp_t e;
        m_lanes[m_ph] = d;
        if (m_ph == L - 1) begin
            e.data = {d, m_lanes[2], m_lanes[1], m_lanes[0]};
            e.last = (m_col == LL / L - 1);
            m_col  = e.last ? 0 : m_col + 1;
            exp_q.push_back(e);
            m_ph = 0;
        end else begin
            m_ph++;
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_valid) begin
                check("hold_data", out_data, prev_data);
                check("hold_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got %h expected none", out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("word_data", out_data, mon_e.data);
                    check("word_last", out_last, mon_e.last);
                end
                n_words++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    // Random downstream backpressure, enabled only for the random test.
    always begin
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // ------------------------------------------------------------------
    // Driver tasks (entered and left at posedge + 1)
    // ------------------------------------------------------------------
    task automatic send_lane(input logic [7:0] d, input bit strict);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        if (strict) check("in_ready_stream", in_ready, 1'b1);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL lane_timeout: got in_ready=0 expected 1 within 100 cycles");
        end else begin
            model_accept(d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int w0;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_phase", phase, 2'd0);
        check("rst_col", col, 8'd0);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Single word
        send_lane(8'h11, 1'b1);
        send_lane(8'h22, 1'b1);
        send_lane(8'h33, 1'b1);
        send_lane(8'h44, 1'b1);
        @(negedge clk);
        check("t1_valid", out_valid, 1'b1);
        check("t1_data", out_data, 32'h44332211);
        check("t1_last", out_last, 1'b0);
        check("t1_phase", phase, 2'd0);
        check("t1_col", col, 8'd1);
        @(negedge clk);
        check("t1_valid_one_cycle", out_valid, 1'b0);
        @(posedge clk);
        #1;

        // Full row, continuous stream
        pulse_reset();
        w0 = n_words;
        for (int i = 0; i < LL; i++) begin
            send_lane(8'(i % 256), 1'b1);
            if (i == LL - 1) begin
                @(negedge clk);
                check("t2_last_word", out_data, 32'h7F7E7D7C);
                check("t2_last_flag", out_last, 1'b1);
                @(posedge clk);
                #1;
            end
        end
        wait_drain();
        check("t2_words", 64'(n_words - w0), 64'd160);
        check("t2_col_wrap", col, 8'd0);

        // Stall with further lanes arriving
        pulse_reset();
        out_ready = 1'b0;
        send_lane(8'h01, 1'b1);
        send_lane(8'h02, 1'b1);
        send_lane(8'h03, 1'b1);
        send_lane(8'h04, 1'b1);
        send_lane(8'h05, 1'b1);
        send_lane(8'h06, 1'b1);
        send_lane(8'h07, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h08;
        repeat (10) begin
            @(negedge clk);
            check("t3_in_ready_stall", in_ready, 1'b0);
        end
        check("t3_phase", phase, 2'd3);
        check("t3_held", out_data, 32'h04030201);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_in_ready_release", in_ready, 1'b1);
        model_accept(8'h08);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("t3_valid_kept", out_valid, 1'b1);
        check("t3_second_word", out_data, 32'h08070605);
        @(posedge clk);
        #1;

        // Reset mid-group discards partial lanes
        pulse_reset();
        send_lane(8'h55, 1'b1);
        send_lane(8'h66, 1'b1);
        pulse_reset();
        send_lane(8'hA1, 1'b1);
        send_lane(8'hA2, 1'b1);
        send_lane(8'hA3, 1'b1);
        send_lane(8'hA4, 1'b1);
        @(negedge clk);
        check("t4_valid", out_valid, 1'b1);
        check("t4_data", out_data, 32'hA4A3A2A1);
        @(posedge clk);
        #1;
        wait_drain();

        // Random valid gaps and random backpressure over one row
        pulse_reset();
        w0 = n_words;
        rnd_ready = 1'b1;
        for (int i = 0; i < LL; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            send_lane(8'($urandom_range(0, 255)), 1'b0);
        end
        rnd_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();
        check("t5_words", 64'(n_words - w0), 64'd160);
        check("t5_col_wrap", col, 8'd0);

        // Reset while a word is held
        pulse_reset();
        out_ready = 1'b0;
        send_lane(8'hC1, 1'b1);
        send_lane(8'hC2, 1'b1);
        send_lane(8'hC3, 1'b1);
        send_lane(8'hC4, 1'b1);
        @(negedge clk);
        check("t6_held_valid", out_valid, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check("t6_valid", out_valid, 1'b0);
        check("t6_data", out_data, 32'h0);
        check("t6_col", col, 8'd0);
        check("t6_phase", phase, 2'd0);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
